// File: rtl/rob_pkg.sv
// rob_pkg: reorder-buffer entry state encoding and age helper.
// Shared by rob_ctrl and rob_age_arbiter.
package rob_pkg;

  localparam int ROB_STATE_W = 3;

  typedef enum logic [ROB_STATE_W-1:0] {
    ROB_IDLE     = 3'd0,
    ROB_STALLED  = 3'd1,
    ROB_READY    = 3'd2,
    ROB_ISSUED   = 3'd3,
    ROB_FINISHED = 3'd4
  } rob_state_e;

  // Age is the distance from head around the ring; smaller is older.
  function automatic logic rob_older(
    int a,
    int b,
    int head,
    int depth
  );
    return ((a - head) & (depth - 1)) < ((b - head) & (depth - 1));
  endfunction

endpackage

// File: rtl/rob_age_arbiter.sv
// rob_age_arbiter: picks the oldest requesting entry relative to head.
// Ports: req (per-entry READY), head -> one-hot grant, grant_idx, any.
module rob_age_arbiter
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  input  logic [IDX_W-1:0] head,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i] && (!any || rob_older(i, int'(grant_idx),
                                       int'(head), DEPTH))) begin
        any       = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder buffer - in-order dispatch, oldest-first issue,
// out-of-order writeback with tag forwarding, in-order commit + squash.
// Ports: clk, rst (sync, active-low); disp_* dispatch handshake and
// operands; iss_* issue handshake; wb_* writeback; cm_* commit
// handshake, squash and redirect; count occupancy.
// Option: ROB_DISP_BYPASS_EN captures same-cycle wb_data at dispatch.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int DATA_W   = 8,
  parameter  int PC_W     = 4,
  parameter  int RF_IDX_W = 2,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_valid,
  output logic                disp_ready,
  output logic [IDX_W-1:0]    disp_idx,
  input  logic [PC_W-1:0]     disp_pc,
  input  logic                disp_rs1_wait,
  input  logic [IDX_W-1:0]    disp_rs1_tag,
  input  logic [DATA_W-1:0]   disp_rs1_data,
  input  logic                disp_rs2_wait,
  input  logic [IDX_W-1:0]    disp_rs2_tag,
  input  logic [DATA_W-1:0]   disp_rs2_data,
  input  logic                disp_wen,
  input  logic [RF_IDX_W-1:0] disp_rd,
  input  logic                disp_is_br,
  input  logic                disp_pred_taken,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [IDX_W-1:0]    iss_idx,
  output logic [PC_W-1:0]     iss_pc,
  output logic [DATA_W-1:0]   iss_rs1_data,
  output logic [DATA_W-1:0]   iss_rs2_data,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                wb_taken,
  input  logic [PC_W-1:0]     wb_next_pc,
  output logic                cm_valid,
  input  logic                cm_ready,
  output logic                cm_wen,
  output logic [RF_IDX_W-1:0] cm_rd,
  output logic [DATA_W-1:0]   cm_data,
  output logic                cm_squash,
  output logic [PC_W-1:0]     cm_next_pc,
  output logic [IDX_W:0]      count
);

  rob_state_e          st    [DEPTH];
  logic [PC_W-1:0]     pc_q  [DEPTH];
  logic [PC_W-1:0]     npc_q [DEPTH];
  logic                w1_q  [DEPTH];
  logic                w2_q  [DEPTH];
  logic [IDX_W-1:0]    t1_q  [DEPTH];
  logic [IDX_W-1:0]    t2_q  [DEPTH];
  logic [DATA_W-1:0]   d1_q  [DEPTH];
  logic [DATA_W-1:0]   d2_q  [DEPTH];
  logic [DATA_W-1:0]   res_q [DEPTH];
  logic                wen_q [DEPTH];
  logic [RF_IDX_W-1:0] rd_q  [DEPTH];
  logic                br_q  [DEPTH];
  logic                pred_q[DEPTH];
  logic                tkn_q [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   cnt;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] gidx;
  logic             any_rdy;

  logic disp_fire, iss_fire, cm_fire, cm_flush, wb_ok;
  logic byp1, byp2;
  logic w1_in, w2_in;
  logic [DATA_W-1:0] d1_in, d2_in;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) rdy[i] = (st[i] == ROB_READY);
  end

  rob_age_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_arb (
    .req       (rdy),
    .head      (head),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any_rdy)
  );

  assign cm_valid   = (st[head] == ROB_FINISHED);
  assign cm_fire    = cm_valid && cm_ready;
  assign cm_squash  = cm_valid && br_q[head] && (pred_q[head] != tkn_q[head]);
  assign cm_flush   = cm_fire && cm_squash;
  assign disp_ready = (cnt < (IDX_W+1)'(DEPTH)) && !cm_flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_idx   = tail;
  assign iss_valid  = any_rdy;
  assign iss_fire   = iss_valid && iss_ready;
  assign wb_ok      = wb_valid && (st[wb_idx] == ROB_ISSUED);
  assign count      = cnt;

  always_comb begin
`ifdef ROB_DISP_BYPASS_EN
    byp1 = disp_rs1_wait && wb_ok && (disp_rs1_tag == wb_idx);
    byp2 = disp_rs2_wait && wb_ok && (disp_rs2_tag == wb_idx);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    w1_in = disp_rs1_wait && !byp1;
    w2_in = disp_rs2_wait && !byp2;
    d1_in = byp1 ? wb_data : disp_rs1_data;
    d2_in = byp2 ? wb_data : disp_rs2_data;
  end

  assign iss_idx      = iss_valid ? gidx : '0;
  assign iss_pc       = iss_valid ? pc_q[gidx] : '0;
  assign iss_rs1_data = iss_valid ? d1_q[gidx] : '0;
  assign iss_rs2_data = iss_valid ? d2_q[gidx] : '0;
  assign cm_wen       = cm_valid && wen_q[head];
  assign cm_rd        = cm_valid ? rd_q[head] : '0;
  assign cm_data      = cm_valid ? res_q[head] : '0;
  assign cm_next_pc   = cm_squash ? npc_q[head] : '0;

  always_ff @(posedge clk) begin
    if (!rst || cm_flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int j = 0; j < DEPTH; j++) st[j] <= ROB_IDLE;
    end else begin
      if (disp_fire) tail <= tail + 1'b1;
      if (cm_fire) head <= head + 1'b1;
      unique case ({disp_fire, cm_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      for (int j = 0; j < DEPTH; j++) begin
        // Wake-up: every finished producer feeds its waiting consumers.
        for (int i = 0; i < DEPTH; i++) begin
          if (st[j] == ROB_STALLED && st[i] == ROB_FINISHED) begin
            if (w1_q[j] && t1_q[j] == IDX_W'(i)) begin
              w1_q[j] <= 1'b0;
              d1_q[j] <= res_q[i];
            end
            if (w2_q[j] && t2_q[j] == IDX_W'(i)) begin
              w2_q[j] <= 1'b0;
              d2_q[j] <= res_q[i];
            end
          end
        end
        unique case (1'b1)
          disp_fire && tail == IDX_W'(j): begin
            st[j]     <= ROB_STALLED;
            pc_q[j]   <= disp_pc;
            w1_q[j]   <= w1_in;
            w2_q[j]   <= w2_in;
            t1_q[j]   <= disp_rs1_tag;
            t2_q[j]   <= disp_rs2_tag;
            d1_q[j]   <= d1_in;
            d2_q[j]   <= d2_in;
            wen_q[j]  <= disp_wen;
            rd_q[j]   <= disp_rd;
            br_q[j]   <= disp_is_br;
            pred_q[j] <= disp_pred_taken;
          end
          st[j] == ROB_STALLED && !w1_q[j] && !w2_q[j]:
            st[j] <= ROB_READY;
          iss_fire && grant[j]:
            st[j] <= ROB_ISSUED;
          wb_ok && wb_idx == IDX_W'(j): begin
            st[j]    <= ROB_FINISHED;
            res_q[j] <= wb_data;
            tkn_q[j] <= wb_taken;
            npc_q[j] <= wb_next_pc;
          end
          cm_fire && head == IDX_W'(j):
            st[j] <= ROB_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed scoreboard bench for rob_ctrl (DEPTH=8).
// Expected issue/commit records are queued; a monitor pops and compares.
module tb_rob_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       disp_valid = 0, disp_ready;
  logic [2:0] disp_idx;
  logic [3:0] disp_pc = 0;
  logic       disp_rs1_wait = 0, disp_rs2_wait = 0;
  logic [2:0] disp_rs1_tag = 0, disp_rs2_tag = 0;
  logic [7:0] disp_rs1_data = 0, disp_rs2_data = 0;
  logic       disp_wen = 0;
  logic [1:0] disp_rd = 0;
  logic       disp_is_br = 0, disp_pred_taken = 0;
  logic       iss_valid, iss_ready = 0;
  logic [2:0] iss_idx;
  logic [3:0] iss_pc;
  logic [7:0] iss_rs1_data, iss_rs2_data;
  logic       wb_valid = 0;
  logic [2:0] wb_idx = 0;
  logic [7:0] wb_data = 0;
  logic       wb_taken = 0;
  logic [3:0] wb_next_pc = 0;
  logic       cm_valid, cm_ready = 0, cm_wen, cm_squash;
  logic [1:0] cm_rd;
  logic [7:0] cm_data;
  logic [3:0] cm_next_pc;
  logic [3:0] count;

  rob_ctrl dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_idx(disp_idx), .disp_pc(disp_pc),
    .disp_rs1_wait(disp_rs1_wait), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs1_data(disp_rs1_data),
    .disp_rs2_wait(disp_rs2_wait), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs2_data(disp_rs2_data),
    .disp_wen(disp_wen), .disp_rd(disp_rd),
    .disp_is_br(disp_is_br), .disp_pred_taken(disp_pred_taken),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_idx(iss_idx), .iss_pc(iss_pc),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .wb_taken(wb_taken), .wb_next_pc(wb_next_pc),
    .cm_valid(cm_valid), .cm_ready(cm_ready),
    .cm_wen(cm_wen), .cm_rd(cm_rd), .cm_data(cm_data),
    .cm_squash(cm_squash), .cm_next_pc(cm_next_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] pc;
    logic [7:0] rs1;
    logic [7:0] rs2;
  } iss_t;

  typedef struct packed {
    logic       wen;
    logic [1:0] rd;
    logic [7:0] data;
    logic       sq;
    logic [3:0] npc;
  } cm_t;

  iss_t exp_iss[$];
  cm_t  exp_cm[$];
  iss_t ei;
  cm_t  ec;

  int checks = 0;
  int errors = 0;
  int tail_m = 0;
  int seq = 1;
  logic [1:0] m_rd [8];
  logic       m_wen[8];
  logic [7:0] m_res[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && iss_valid && iss_ready) begin
      if (exp_iss.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL iss_extra got idx %0d want none", iss_idx);
      end else begin
        ei = exp_iss.pop_front();
        chk("iss_idx", 32'(iss_idx), 32'(ei.idx));
        chk("iss_pc", 32'(iss_pc), 32'(ei.pc));
        chk("iss_rs1", 32'(iss_rs1_data), 32'(ei.rs1));
        chk("iss_rs2", 32'(iss_rs2_data), 32'(ei.rs2));
      end
    end
    if (rst && cm_valid && cm_ready) begin
      if (exp_cm.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cm_extra got rd %0d want none", cm_rd);
      end else begin
        ec = exp_cm.pop_front();
        chk("cm_wen", 32'(cm_wen), 32'(ec.wen));
        chk("cm_rd", 32'(cm_rd), 32'(ec.rd));
        chk("cm_data", 32'(cm_data), 32'(ec.data));
        chk("cm_squash", 32'(cm_squash), 32'(ec.sq));
        chk("cm_next_pc", 32'(cm_next_pc), 32'(ec.npc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] pc,
                      input logic w1, input logic [2:0] t1,
                      input logic [7:0] d1,
                      input logic w2, input logic [2:0] t2,
                      input logic [7:0] d2,
                      input logic wen, input logic [1:0] rd,
                      input logic br, input logic pred);
    disp_pc = pc;
    disp_rs1_wait = w1; disp_rs1_tag = t1; disp_rs1_data = d1;
    disp_rs2_wait = w2; disp_rs2_tag = t2; disp_rs2_data = d2;
    disp_wen = wen; disp_rd = rd;
    disp_is_br = br; disp_pred_taken = pred;
    disp_valid = 1'b1;
    #1;
    chk("disp_ready", 32'(disp_ready), 32'd1);
    chk("disp_idx", 32'(disp_idx), 32'(tail_m));
    m_rd[tail_m]  = rd;
    m_wen[tail_m] = wen;
    tick();
    disp_valid = 1'b0;
    tail_m = (tail_m + 1) % 8;
  endtask

  task automatic wb(input logic [2:0] idx, input logic [7:0] d,
                    input logic tk, input logic [3:0] np);
    wb_valid = 1'b1;
    wb_idx = idx; wb_data = d; wb_taken = tk; wb_next_pc = np;
    m_res[idx] = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic push_iss(input logic [2:0] idx, input logic [3:0] pc,
                          input logic [7:0] r1, input logic [7:0] r2);
    iss_t e;
    e.idx = idx; e.pc = pc; e.rs1 = r1; e.rs2 = r2;
    exp_iss.push_back(e);
  endtask

  task automatic push_cm(input logic wen, input logic [1:0] rd,
                         input logic [7:0] d, input logic sq,
                         input logic [3:0] np);
    cm_t e;
    e.wen = wen; e.rd = rd; e.data = d; e.sq = sq; e.npc = np;
    exp_cm.push_back(e);
  endtask

  task automatic push_cm_for(input int idx);
    push_cm(m_wen[idx], m_rd[idx], m_res[idx], 1'b0, 4'd0);
  endtask

  task automatic drain_iss(input int left);
    int n;
    n = 0;
    iss_ready = 1'b1;
    while (exp_iss.size() > left && n < 40) begin
      tick();
      n++;
    end
    iss_ready = 1'b0;
    if (exp_iss.size() > left) begin
      checks++;
      errors++;
      $display("FAIL iss_timeout got %0d pending want %0d",
               exp_iss.size(), left);
    end
  endtask

  task automatic drain_cm(input int left);
    int n;
    n = 0;
    cm_ready = 1'b1;
    while (exp_cm.size() > left && n < 40) begin
      tick();
      n++;
    end
    cm_ready = 1'b0;
    if (exp_cm.size() > left) begin
      checks++;
      errors++;
      $display("FAIL cm_timeout got %0d pending want %0d",
               exp_cm.size(), left);
    end
  endtask

  task automatic run_indep(input int n);
    int start;
    logic [2:0] idx;
    logic [3:0] pc;
    logic [7:0] d1, d2;
    start = tail_m;
    for (int k = 0; k < n; k++) begin
      idx = 3'(start + k);
      pc  = 4'(seq + 3);
      d1  = 8'(seq * 5);
      d2  = 8'(seq * 7 + 1);
      disp(pc, 1'b0, 3'd0, d1, 1'b0, 3'd0, d2, 1'b1, 2'(seq),
           1'b0, 1'b0);
      push_iss(idx, pc, d1, d2);
      seq++;
    end
    drain_iss(0);
    for (int k = 0; k < n; k++) begin
      idx = 3'(start + k);
      wb(idx, 8'(seq * 11 + k), 1'b0, 4'd0);
      push_cm_for(int'(idx));
    end
    drain_cm(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int order[7];
    // Reset
    repeat (2) tick();
    rst = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_cm_valid", 32'(cm_valid), 32'd0);

    // Fill to full, then free one slot
    for (int k = 0; k < 8; k++) begin
      disp(4'(k), 1'b0, 3'd0, 8'(k + 16), 1'b0, 3'd0, 8'(k + 32),
           1'b1, 2'(k), 1'b0, 1'b0);
      push_iss(3'(k), 4'(k), 8'(k + 16), 8'(k + 32));
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    drain_iss(0);
    for (int k = 0; k < 8; k++) begin
      wb(3'(k), 8'(k + 64), 1'b0, 4'd0);
      push_cm_for(k);
    end
    cm_ready = 1'b1;
    #1;
    chk("full_cm_valid", 32'(cm_valid), 32'd1);
    tick();
    cm_ready = 1'b0;
    chk("after1_disp_ready", 32'(disp_ready), 32'd1);
    chk("after1_count", 32'(count), 32'd7);
    drain_cm(0);
    chk("drained_count", 32'(count), 32'd0);

    // Forwarding: B waits on A
    disp(4'd3, 1'b0, 3'd0, 8'h01, 1'b0, 3'd0, 8'h02, 1'b1, 2'd1,
         1'b0, 1'b0);
    disp(4'd4, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h07, 1'b1, 2'd2,
         1'b0, 1'b0);
    push_iss(3'd0, 4'd3, 8'h01, 8'h02);
    push_iss(3'd1, 4'd4, 8'h5A, 8'h07);
    drain_iss(1);
    wb(3'd0, 8'h5A, 1'b0, 4'd0);
    drain_iss(0);
    wb(3'd1, 8'h33, 1'b0, 4'd0);
    push_cm_for(0);
    push_cm_for(1);
    drain_cm(0);

    // Move head to 5, then oldest-first across the wrap
    run_indep(3);
    disp(4'd5, 1'b0, 3'd0, 8'h50, 1'b0, 3'd0, 8'h51, 1'b1, 2'd1,
         1'b0, 1'b0);
    push_iss(3'd5, 4'd5, 8'h50, 8'h51);
    drain_iss(0);
    disp(4'd6, 1'b0, 3'd0, 8'h60, 1'b0, 3'd0, 8'h61, 1'b1, 2'd2,
         1'b0, 1'b0);
    disp(4'd7, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 8'h71, 1'b1, 2'd3,
         1'b0, 1'b0);
    disp(4'd8, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 8'h01, 1'b1, 2'd0,
         1'b0, 1'b0);
    disp(4'd9, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 8'h11, 1'b1, 2'd1,
         1'b0, 1'b0);
    disp(4'd10, 1'b0, 3'd0, 8'h21, 1'b1, 3'd5, 8'h00, 1'b1, 2'd2,
         1'b0, 1'b0);
    disp(4'd11, 1'b0, 3'd0, 8'h30, 1'b0, 3'd0, 8'h31, 1'b1, 2'd3,
         1'b0, 1'b0);
    tick();
    tick();
    chk("age_iss_valid", 32'(iss_valid), 32'd1);
    chk("age_iss_idx", 32'(iss_idx), 32'd6);
    push_iss(3'd6, 4'd6, 8'h60, 8'h61);
    push_iss(3'd3, 4'd11, 8'h30, 8'h31);
    drain_iss(0);
    wb(3'd5, 8'h11, 1'b0, 4'd0);
    push_iss(3'd7, 4'd7, 8'h11, 8'h71);
    push_iss(3'd0, 4'd8, 8'h11, 8'h01);
    push_iss(3'd1, 4'd9, 8'h11, 8'h11);
    push_iss(3'd2, 4'd10, 8'h21, 8'h11);
    drain_iss(0);
    wb(3'd6, 8'h66, 1'b0, 4'd0);
    wb(3'd3, 8'h3C, 1'b0, 4'd0);
    wb(3'd7, 8'h77, 1'b0, 4'd0);
    wb(3'd0, 8'h0F, 1'b0, 4'd0);
    wb(3'd1, 8'h1E, 1'b0, 4'd0);
    wb(3'd2, 8'h2D, 1'b0, 4'd0);
    order = '{5, 6, 7, 0, 1, 2, 3};
    for (int k = 0; k < 7; k++) push_cm_for(order[k]);
    drain_cm(0);

    // Mispredicted branch at head squashes everything
    disp(4'd9, 1'b0, 3'd0, 8'h01, 1'b0, 3'd0, 8'h02, 1'b0, 2'd0,
         1'b1, 1'b0);
    disp(4'd2, 1'b0, 3'd0, 8'h03, 1'b0, 3'd0, 8'h04, 1'b1, 2'd1,
         1'b0, 1'b0);
    push_iss(3'd4, 4'd9, 8'h01, 8'h02);
    drain_iss(0);
    wb(3'd4, 8'h00, 1'b1, 4'hC);
    chk("br_cm_valid", 32'(cm_valid), 32'd1);
    chk("br_cm_squash", 32'(cm_squash), 32'd1);
    chk("br_cm_next_pc", 32'(cm_next_pc), 32'hC);
    push_cm(1'b0, 2'd0, 8'h00, 1'b1, 4'hC);
    cm_ready = 1'b1;
    tick();
    cm_ready = 1'b0;
    tail_m = 0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_disp_idx", 32'(disp_idx), 32'd0);
    chk("flush_iss_valid", 32'(iss_valid), 32'd0);
    chk("flush_cm_valid", 32'(cm_valid), 32'd0);

    // Dispatch racing the producer's writeback
    disp(4'd1, 1'b0, 3'd0, 8'h0A, 1'b0, 3'd0, 8'h0B, 1'b1, 2'd3,
         1'b0, 1'b0);
    push_iss(3'd0, 4'd1, 8'h0A, 8'h0B);
    drain_iss(0);
    wb_valid = 1'b1; wb_idx = 3'd0; wb_data = 8'h77;
    wb_taken = 1'b0; wb_next_pc = 4'd0;
    m_res[0] = 8'h77;
    disp(4'd2, 1'b1, 3'd0, 8'hEE, 1'b0, 3'd0, 8'h22, 1'b1, 2'd2,
         1'b0, 1'b0);
    wb_valid = 1'b0;
    lat = 0;
    while (!iss_valid && lat < 10) begin
      tick();
      lat++;
    end
`ifdef ROB_DISP_BYPASS_EN
    chk("byp_latency", 32'(lat), 32'd1);
`else
    chk("byp_latency", 32'(lat), 32'd2);
`endif
    chk("byp_rs1", 32'(iss_rs1_data), 32'h77);
    push_iss(3'd1, 4'd2, 8'h77, 8'h22);
    drain_iss(0);
    wb(3'd1, 8'h99, 1'b0, 4'd0);
    push_cm_for(0);
    push_cm_for(1);
    drain_cm(0);

    // Wrap: single dispatch/commit pairs
    for (int k = 0; k < 20; k++) run_indep(1);

    // Reset in the middle of operation
    disp(4'd1, 1'b0, 3'd0, 8'h01, 1'b0, 3'd0, 8'h02, 1'b1, 2'd0,
         1'b0, 1'b0);
    disp(4'd2, 1'b0, 3'd0, 8'h03, 1'b0, 3'd0, 8'h04, 1'b1, 2'd1,
         1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tail_m = 0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_disp_ready", 32'(disp_ready), 32'd1);
    chk("mrst_iss_valid", 32'(iss_valid), 32'd0);
    chk("mrst_cm_valid", 32'(cm_valid), 32'd0);
    chk("mrst_cm_squash", 32'(cm_squash), 32'd0);
    chk("mrst_disp_idx", 32'(disp_idx), 32'd0);

    tick();
    chk("iss_q_empty", 32'(exp_iss.size()), 32'd0);
    chk("cm_q_empty", 32'(exp_cm.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
